// File: rtl/key_step_debounce.sv
// key_step_debounce: turns the raw active-low single-step push-button into one clean processor
// clock pulse of fixed width plus a one-cycle strobe, and counts the accepted steps.
//
// Ports:
//   clk         in   board clock
//   rst         in   asynchronous active-low reset
//   key_n       in   raw button, asynchronous, 0 = pressed
//   step_clk    out  clean processor clock, high for STEP_HIGH cycles per step
//   step_pulse  out  one-cycle strobe coincident with the step_clk rising edge
//   key_pressed out  debounced key state, 1 = pressed
//   step_count  out  number of accepted steps, wraps at 16 bits
//
// Build option: define KEY_STEP_AUTO_REPEAT_EN to auto-repeat steps while the key is held
// (first repeat REPEAT_DELAY cycles after the press step, then every REPEAT_PERIOD cycles).
module key_step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned STEP_HIGH       = 25,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  output logic        step_clk,
  output logic        step_pulse,
  output logic        key_pressed,
  output logic [15:0] step_count
);

  // Elaboration-time sanity checks on the configuration.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (STEP_HIGH < 1) begin : g_bad_step_high
    $error("STEP_HIGH must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD <= 2 * STEP_HIGH) begin : g_bad_repeat
    $error("REPEAT_DELAY must be >= 1 and REPEAT_PERIOD > 2*STEP_HIGH");
  end

  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HighLast = CNT_W'(STEP_HIGH - 1);

  typedef enum logic [1:0] {StReleased, StPressWait, StPressed, StReleaseWait} state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic [CNT_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic               step_clk_q, step_clk_d;
  logic               step_pulse_q, step_pulse_d;
  logic               key_pressed_q, key_pressed_d;
  logic [15:0]        step_count_q, step_count_d;
  logic               press_fire;
  logic               repeat_fire;

  // Debounce FSM; the counter holds the number of consecutive cycles seen at the new level.
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    press_fire = 1'b0;
    unique case (state_q)
      StReleased: begin
        if (!sync2_q) begin
          state_d   = StPressWait;
          deb_cnt_d = CNT_W'(1);
        end
      end
      StPressWait: begin
        if (sync2_q) begin
          state_d   = StReleased;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StPressed;
          deb_cnt_d  = '0;
          press_fire = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      StPressed: begin
        if (sync2_q) begin
          state_d   = StReleaseWait;
          deb_cnt_d = CNT_W'(1);
        end
      end
      StReleaseWait: begin
        if (!sync2_q) begin
          state_d   = StPressed;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d   = StReleased;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = StReleased;
        deb_cnt_d = '0;
      end
    endcase
    key_pressed_d = (state_d == StPressed) || (state_d == StReleaseWait);
  end

`ifdef KEY_STEP_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Hold counter counts down to the next repeat; it is zero whenever not in StPressed and is
  // reloaded with the initial delay on every entry to StPressed.
  always_comb begin
    hold_cnt_d  = '0;
    repeat_fire = 1'b0;
    if (state_d == StPressed) begin
      if (state_q != StPressed) begin
        hold_cnt_d = DelayLast;
      end else if (hold_cnt_q == '0) begin
        repeat_fire = 1'b1;
        hold_cnt_d  = PeriodLast;
      end else begin
        hold_cnt_d = hold_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  // Step generator: a fire request while step_clk is still high is dropped.
  always_comb begin
    step_clk_d   = step_clk_q;
    step_pulse_d = 1'b0;
    hi_cnt_d     = hi_cnt_q;
    step_count_d = step_count_q;
    if (step_clk_q) begin
      if (hi_cnt_q == '0) begin
        step_clk_d = 1'b0;
      end else begin
        hi_cnt_d = hi_cnt_q - CNT_W'(1);
      end
    end else if (press_fire || repeat_fire) begin
      step_clk_d   = 1'b1;
      step_pulse_d = 1'b1;
      hi_cnt_d     = HighLast;
      step_count_d = step_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= StReleased;
      deb_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      step_clk_q    <= 1'b0;
      step_pulse_q  <= 1'b0;
      key_pressed_q <= 1'b0;
      step_count_q  <= '0;
    end else begin
      sync1_q       <= key_n;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      deb_cnt_q     <= deb_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      step_clk_q    <= step_clk_d;
      step_pulse_q  <= step_pulse_d;
      key_pressed_q <= key_pressed_d;
      step_count_q  <= step_count_d;
    end
  end

  assign step_clk    = step_clk_q;
  assign step_pulse  = step_pulse_q;
  assign key_pressed = key_pressed_q;
  assign step_count  = step_count_q;

endmodule

// File: tb/tb_key_step_debounce.sv
// Directed self-checking bench for key_step_debounce with DEBOUNCE_CYCLES=4, STEP_HIGH=2,
// REPEAT_DELAY=12, REPEAT_PERIOD=6. Cycle index i below is the i-th rising edge after key_n
// (or rst) was driven at a falling edge; a press step appears right after edge 5.
module tb_key_step_debounce;

  logic        clk;
  logic        rst;
  logic        key_n;
  logic        step_clk;
  logic        step_pulse;
  logic        key_pressed;
  logic [15:0] step_count;

  int          n_tests;
  int          n_fail;
  logic [15:0] exp_count;

  key_step_debounce #(
    .DEBOUNCE_CYCLES(4),
    .STEP_HIGH      (2),
    .REPEAT_DELAY   (12),
    .REPEAT_PERIOD  (6),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .step_clk   (step_clk),
    .step_pulse (step_pulse),
    .key_pressed(key_pressed),
    .step_count (step_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One rising edge, then return to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_key();
    key_n = 1'b1;
    repeat (8) tick();
  endtask

  // Expected step cycles for a long hold starting at cycle 0 and released before edge 44.
  function automatic bit is_step(int i);
`ifdef KEY_STEP_AUTO_REPEAT_EN
    return (i == 5) || (i >= 17 && i <= 41 && ((i - 17) % 6) == 0);
`else
    return (i == 5);
`endif
  endfunction

  task automatic test_reset();
    logic exp_p;
    rst   = 1'b0;
    key_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (step_clk !== 1'b0) begin
      n_fail++; $display("FAIL reset_step_clk: got %0b expected 0", step_clk);
    end
    n_tests++;
    if (step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_step_pulse: got %0b expected 0", step_pulse);
    end
    n_tests++;
    if (key_pressed !== 1'b0) begin
      n_fail++; $display("FAIL reset_key_pressed: got %0b expected 0", key_pressed);
    end
    n_tests++;
    if (step_count !== 16'h0000) begin
      n_fail++; $display("FAIL reset_step_count: got %h expected 0000", step_count);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_p = (i == 5);
      n_tests++;
      if (step_pulse !== exp_p) begin
        n_fail++;
        $display("FAIL reset_first_pulse cyc %0d: got %0b expected %0b", i, step_pulse, exp_p);
      end
      if (i == 5) begin
        n_tests++;
        if (step_count !== 16'd1) begin
          n_fail++; $display("FAIL reset_first_count: got %0d expected 1", step_count);
        end
      end
    end
    exp_count = 16'd1;
    release_key();
  endtask

  task automatic test_clean_press();
    logic exp_p, exp_c, exp_k;
`ifdef KEY_STEP_AUTO_REPEAT_EN
    int hold = 12;  // release before the first auto-repeat would fire
`else
    int hold = 20;
`endif
    key_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      exp_p = (i == 5);
      exp_c = (i == 5) || (i == 6);
      exp_k = (i >= 5);
      n_tests++;
      if (step_pulse !== exp_p) begin
        n_fail++;
        $display("FAIL press_pulse cyc %0d: got %0b expected %0b", i, step_pulse, exp_p);
      end
      n_tests++;
      if (step_clk !== exp_c) begin
        n_fail++;
        $display("FAIL press_step_clk cyc %0d: got %0b expected %0b", i, step_clk, exp_c);
      end
      n_tests++;
      if (key_pressed !== exp_k) begin
        n_fail++;
        $display("FAIL press_key_pressed cyc %0d: got %0b expected %0b", i, key_pressed, exp_k);
      end
    end
    exp_count = exp_count + 16'd1;
    n_tests++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL press_count: got %0d expected %0d", step_count, exp_count);
    end
    key_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_k = (i < 5);
      n_tests++;
      if (key_pressed !== exp_k) begin
        n_fail++;
        $display("FAIL release_key_pressed cyc %0d: got %0b expected %0b", i, key_pressed, exp_k);
      end
      n_tests++;
      if (step_pulse !== 1'b0) begin
        n_fail++; $display("FAIL release_pulse cyc %0d: got %0b expected 0", i, step_pulse);
      end
    end
    n_tests++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL release_count: got %0d expected %0d", step_count, exp_count);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 16; i++) begin
      key_n = (i == 3) || (i >= 7);
      tick();
      n_tests++;
      if (step_pulse !== 1'b0) begin
        n_fail++; $display("FAIL bounce_pulse cyc %0d: got %0b expected 0", i, step_pulse);
      end
      n_tests++;
      if (key_pressed !== 1'b0) begin
        n_fail++; $display("FAIL bounce_key_pressed cyc %0d: got %0b expected 0", i, key_pressed);
      end
    end
    n_tests++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL bounce_count: got %0d expected %0d", step_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    force dut.step_count_q = 16'hFFFF;
    tick();
    release dut.step_count_q;
    key_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 5) begin
        n_tests++;
        if (step_pulse !== 1'b1) begin
          n_fail++; $display("FAIL wrap_pulse: got %0b expected 1", step_pulse);
        end
        n_tests++;
        if (step_count !== 16'h0000) begin
          n_fail++; $display("FAIL wrap_count: got %h expected 0000", step_count);
        end
      end
    end
    exp_count = 16'h0000;
    release_key();
  endtask

  task automatic test_reset_mid_pulse();
    logic exp_p;
    key_n = 1'b0;
    repeat (6) tick();
    @(posedge clk);  // edge 6: second step_clk high cycle
    #1;
    n_tests++;
    if (step_clk !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre_step_clk: got %0b expected 1", step_clk);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (step_clk !== 1'b0) begin
      n_fail++; $display("FAIL midrst_step_clk: got %0b expected 0", step_clk);
    end
    n_tests++;
    if (step_count !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_count: got %0d expected 0", step_count);
    end
    n_tests++;
    if (key_pressed !== 1'b0) begin
      n_fail++; $display("FAIL midrst_key_pressed: got %0b expected 0", key_pressed);
    end
    @(negedge clk);
    rst = 1'b1;  // key still held: a full debounce is needed again
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_p = (i == 5);
      n_tests++;
      if (step_pulse !== exp_p) begin
        n_fail++;
        $display("FAIL midrst_repress_pulse cyc %0d: got %0b expected %0b", i, step_pulse, exp_p);
      end
    end
    exp_count = 16'd1;
    n_tests++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL midrst_repress_count: got %0d expected %0d", step_count, exp_count);
    end
    release_key();
  endtask

  task automatic test_auto_repeat();
    logic exp_p, exp_c;
    int   n_steps = 0;
    key_n = 1'b0;
    for (int i = 0; i < 61; i++) begin
      if (i == 44) key_n = 1'b1;
      tick();
      exp_p = is_step(i);
      exp_c = is_step(i) || is_step(i - 1);
      if (exp_p) n_steps++;
      n_tests++;
      if (step_pulse !== exp_p) begin
        n_fail++;
        $display("FAIL repeat_pulse cyc %0d: got %0b expected %0b", i, step_pulse, exp_p);
      end
      n_tests++;
      if (step_clk !== exp_c) begin
        n_fail++;
        $display("FAIL repeat_step_clk cyc %0d: got %0b expected %0b", i, step_clk, exp_c);
      end
    end
    exp_count = exp_count + 16'(n_steps);
    n_tests++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL repeat_count: got %0d expected %0d", step_count, exp_count);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_count = '0;
    rst       = 1'b0;
    key_n     = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_reset_mid_pulse();
    test_auto_repeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
